reg_piso_tx: RTL
================

Name: reg_piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the unload/read side for words held in the team's loadable registers.
- Captures an n-bit word on `ld` and shifts it out MSB-first, one bit per accepted handshake (`ser_valid`/`ser_ack`).
- Pulses `done` after the last bit, then returns to idle.
- Sits between a datapath register and a bit-serial consumer, e.g. an LED/shift-chain driver or a serial link.

Parameters:
- n, 8, word width in bits; legal range n >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high reset; sampled only on the rising clk edge; overrides all other inputs.
- data_in  input  n  parallel word to transmit.
- ld  input  1  load request; honoured only when rdy=1.
- ser_ack  input  1  consumer accepts the current bit this cycle.
- rdy  output  1  block is idle and will accept ld.
- ser_out  output  1  current serial bit; equals shreg[n-1] while ser_valid=1, 0 otherwise.
- ser_valid  output  1  ser_out holds a valid bit.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (clr=1 at an edge): state<=IDLE, shreg<=0, cnt<=0. Next cycle: rdy=1, ser_valid=0, ser_out=0, done=0.
- clr mid-transfer aborts the word immediately. No done pulse; remaining bits are lost.
- Internal state: shreg [n-1:0]; cnt [$clog2(n)-1:0]; FSM with states IDLE, SHIFT, DONE.
- Outputs are Moore-decoded from state and shreg:
  - IDLE: rdy=1, all other outputs 0.
  - SHIFT: ser_valid=1, ser_out=shreg[n-1], rdy=0, done=0.
  - DONE: done=1, all other outputs 0.
- IDLE:
  - ld=1: shreg<=data_in, cnt<=n-1, go SHIFT.
  - ld=0: hold.
- SHIFT, ser_ack=0: hold shreg, cnt and state. The bit stays valid indefinitely (stall); no timeout.
- SHIFT, ser_ack=1:
  - shreg<={shreg[n-2:0],1'b0}.
  - cnt!=0: cnt<=cnt-1, stay SHIFT.
  - cnt==0: go DONE.
- DONE: unconditionally go IDLE next edge. done is high for exactly one cycle.
- ld while state!=IDLE is ignored; no queuing, and data_in is not sampled.
- ld in the same cycle as clr: clr wins and the word is not captured.
- ser_ack while not in SHIFT is ignored.
- Latency with ser_ack held high:
  - ld sampled at edge E0.
  - Bit n-1 is valid in the cycle after E0.
  - Bit 0 is accepted at edge E(n).
  - done is high in the cycle after E(n).
  - rdy returns one cycle later, at E(n+2).
  - Back-to-back words therefore cost n+2 cycles each.
- ser_out must never glitch to a new bit without a preceding accepted ser_ack.
- Exactly n accepted handshakes occur per loaded word.

Test Plan:
- Reset: hold clr=1 for 2 cycles, then release -> rdy=1, ser_valid=0, ser_out=0, done=0.
- Basic transfer, n=8, ser_ack tied 1: load 8'hA5 -> ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with ser_valid=1; done=1 on cycle 9 only; rdy=1 on cycle 10.
- Backpressure: load 8'h81 and drop ser_ack for 3 cycles after the first and fifth bits -> ser_out and ser_valid stay constant during the stalls; sequence still 1,0,0,0,0,0,0,1; done after the 8th ack only.
- Ignored load: load 8'hF0, then assert ld with data_in=8'h0F during bits 2-4 -> output remains 1,1,1,1,0,0,0,0; no second transfer starts.
- Mid-transfer reset: load 8'hFF, assert clr after the 3rd ack -> next cycle ser_valid=0, rdy=1, no done pulse; a subsequent load of 8'h3C transmits 0,0,1,1,1,1,0,0 correctly.
- Width check, n=2: load 2'b10 with ack=1 -> ser_out 1 then 0; done on cycle 3; rdy on cycle 4.

Source files
------------

// File: rtl/reg_piso_tx.sv
// Parallel-in serial-out transmitter: captures a word on ld and
// shifts it out MSB-first, one bit per accepted ser_valid/ser_ack.
module reg_piso_tx #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [n-1:0] data_in,
   input  logic         ld,
   input  logic         ser_ack,
   output logic         rdy,
   output logic         ser_out,
   output logic         ser_valid,
   output logic         done
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state, state_nx;
   logic [n-1:0]  shreg, shreg_nx;
   logic [CW-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         shreg <= shreg_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (ld) begin
               shreg_nx = data_in;
               cnt_nx   = CW'(n - 1);
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ack) begin
               shreg_nx = {shreg[n-2:0], 1'b0};
               if (cnt != '0) cnt_nx = cnt - 1'b1;
               else           state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Moore outputs; ser_out is gated so it reads 0 outside SHIFT
   assign rdy       = (state == IDLE);
   assign ser_valid = (state == SHIFT);
   assign ser_out   = ser_valid & shreg[n-1];
   assign done      = (state == DONE);

endmodule
